// File: rtl/send.sv
// Write-side burst producer for the async FIFO (clk_w domain).
// Ports: clk_w/reset, start/abort/burst_len/seed in, overflow from FIFO;
// data_w/wr_en to FIFO, busy/done/sent_cnt status. Macro: SEND_PRBS_EN.
module send #(
  parameter int DW    = 8,
  parameter int LEN_W = 8,
  parameter int GAP   = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk_w,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [DW-1:0]    seed,
  input  logic             overflow,
  output logic [DW-1:0]    data_w,
  output logic             wr_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_cnt
);

  localparam int GW = $clog2(GAP + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic [DW-1:0]    data_q, data_d;
  logic             wr_en_q, wr_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] sent_cnt_q, sent_cnt_d;
  logic             accept;
  logic [DW-1:0]    seed_l;

  function automatic logic [DW-1:0] nxt(input logic [DW-1:0] d);
`ifdef SEND_PRBS_EN
    return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
`else
    return d + DW'(1);
`endif
  endfunction

  // A zero seed would lock the LFSR, so it is swapped for 1.
`ifdef SEND_PRBS_EN
  assign seed_l = (seed == '0) ? DW'(1) : seed;
`else
  assign seed_l = seed;
`endif

  assign accept = wr_en_q && !overflow;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    gap_cnt_d   = gap_cnt_q;
    data_d      = data_q;
    wr_en_d     = wr_en_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sent_cnt_d  = sent_cnt_q;
    if (accept) begin
      sent_cnt_d = sent_cnt_q + CNT_W'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (burst_len != '0) begin
            remaining_d = burst_len;
            data_d      = seed_l;
            wr_en_d     = 1'b1;
            busy_d      = 1'b1;
            state_d     = S_SEND;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (abort) begin
          state_d = S_IDLE;
          wr_en_d = 1'b0;
          busy_d  = 1'b0;
        end else if (accept) begin
          if (remaining_q > LEN_W'(1)) begin
            data_d      = nxt(data_q);
            remaining_d = remaining_q - LEN_W'(1);
          end else begin
            wr_en_d     = 1'b0;
            remaining_d = '0;
            if (GAP > 0) begin
              state_d   = S_GAP;
              gap_cnt_d = GW'(GAP);
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
          wr_en_d = 1'b0;
          busy_d  = 1'b0;
        end else if (gap_cnt_q == GW'(1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        wr_en_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_w) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      gap_cnt_q   <= '0;
      data_q      <= '0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sent_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      gap_cnt_q   <= gap_cnt_d;
      data_q      <= data_d;
      wr_en_q     <= wr_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sent_cnt_q  <= sent_cnt_d;
    end
  end

  assign data_w   = data_q;
  assign wr_en    = wr_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sent_cnt = sent_cnt_q;

endmodule

// File: tb/tb_send.sv
// Directed testbench for send: burst, backpressure, zero length,
// busy start, abort, reset mid-burst and the PRBS pattern.
module tb_send;

  logic        clk_w = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  burst_len = '0;
  logic [7:0]  seed = '0;
  logic        overflow = 1'b0;
  logic [7:0]  data_w;
  logic        wr_en;
  logic        busy;
  logic        done;
  logic [15:0] sent_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cnt = '0;

  send dut (
    .clk_w(clk_w), .reset(reset), .start(start), .abort(abort),
    .burst_len(burst_len), .seed(seed), .overflow(overflow),
    .data_w(data_w), .wr_en(wr_en), .busy(busy), .done(done),
    .sent_cnt(sent_cnt)
  );

  always #5 clk_w = ~clk_w;

  task automatic tick();
    @(posedge clk_w);
    #1;
  endtask

  function automatic logic [7:0] exp_next(input logic [7:0] d);
`ifdef SEND_PRBS_EN
    return {d[6:0], ^(d & 8'hB8)};
`else
    return 8'(d + 8'd1);
`endif
  endfunction

  function automatic logic [7:0] exp_seed(input logic [7:0] s);
`ifdef SEND_PRBS_EN
    return (s == 8'h00) ? 8'h01 : s;
`else
    return s;
`endif
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({data_w, wr_en, busy, done, sent_cnt} !== 27'd0) begin
      errors++;
      $display("FAIL reset: got d=%h w=%b b=%b dn=%b c=%0d want all 0",
               data_w, wr_en, busy, done, sent_cnt);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_burst();
    logic [7:0] d;
    d = exp_seed(8'h10);
    burst_len = 8'd4;
    seed = 8'h10;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_en !== 1'b1 || data_w !== d || busy !== 1'b1) begin
        errors++;
        $display("FAIL burst beat%0d: got w=%b d=%h b=%b want 1 %h 1",
                 i, wr_en, data_w, busy, d);
      end
      d = exp_next(d);
      exp_cnt++;
      tick();
    end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (wr_en !== 1'b0 || done !== (i == 3)) begin
        errors++;
        $display("FAIL burst gap%0d: got w=%b done=%b want 0 %b",
                 i, wr_en, done, (i == 3));
      end
      if (i < 4) tick();
    end
    checks++;
    if (sent_cnt !== exp_cnt || busy !== 1'b0) begin
      errors++;
      $display("FAIL burst cnt: got %0d b=%b want %0d 0",
               sent_cnt, busy, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] d0, d1, d2;
    logic       seen;
    d0 = exp_seed(8'hFE);
    d1 = exp_next(d0);
    d2 = exp_next(d1);
    burst_len = 8'd3;
    seed = 8'hFE;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (wr_en !== 1'b1 || data_w !== d0) begin
      errors++;
      $display("FAIL bp beat0: got %b %h want 1 %h", wr_en, data_w, d0);
    end
    tick();
    exp_cnt++;
    overflow = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_en !== 1'b1 || data_w !== d1) begin
        errors++;
        $display("FAIL bp stall%0d: got %b %h want 1 %h",
                 i, wr_en, data_w, d1);
      end
      if (i == 2) overflow = 1'b0;
      tick();
    end
    exp_cnt++;
    checks++;
    if (wr_en !== 1'b1 || data_w !== d2) begin
      errors++;
      $display("FAIL bp beat2: got %b %h want 1 %h", wr_en, data_w, d2);
    end
    tick();
    exp_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (done) seen = 1'b1;
      else tick();
    end
    checks++;
    if (!seen || sent_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL bp done/cnt: got done=%b cnt=%0d want 1 %0d",
               seen, sent_cnt, exp_cnt);
    end
    tick();
  endtask

  task automatic test_zero_len();
    burst_len = 8'd0;
    seed = 8'h33;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_len: got done=%b w=%b b=%b want 1 0 0",
               done, wr_en, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || wr_en !== 1'b0 || sent_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL zero_len after: got done=%b w=%b c=%0d want 0 0 %0d",
               done, wr_en, sent_cnt, exp_cnt);
    end
  endtask

  task automatic test_busy_start();
    int beats;
    logic seen;
    burst_len = 8'd2;
    seed = 8'h40;
    start = 1'b1;
    tick();
    burst_len = 8'd5;
    beats = 0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (wr_en) beats++;
      if (done) seen = 1'b1;
      if (i == 1) start = 1'b0;
      tick();
    end
    exp_cnt += 16'd2;
    checks++;
    if (beats != 2 || !seen || sent_cnt !== exp_cnt || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start: got beats=%0d done=%b c=%0d b=%b want 2 1 %0d 0",
               beats, seen, sent_cnt, busy, exp_cnt);
    end
  endtask

  task automatic test_abort();
    logic seen;
    burst_len = 8'd10;
    seed = 8'h20;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    abort = 1'b1;
    overflow = 1'b1;
    tick();
    abort = 1'b0;
    overflow = 1'b0;
    exp_cnt += 16'd3;
    checks++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || sent_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL abort: got w=%b b=%b c=%0d want 0 0 %0d",
               wr_en, busy, sent_cnt, exp_cnt);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort no_done: got done seen=%b want 0", seen);
    end
    burst_len = 8'd1;
    seed = 8'h55;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (wr_en !== 1'b1 || data_w !== exp_seed(8'h55)) begin
      errors++;
      $display("FAIL abort restart: got %b %h want 1 %h",
               wr_en, data_w, exp_seed(8'h55));
    end
    tick();
    exp_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (done) seen = 1'b1;
      else tick();
    end
    checks++;
    if (!seen || sent_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL abort restart done: got done=%b c=%0d want 1 %0d",
               seen, sent_cnt, exp_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    logic seen;
    burst_len = 8'd8;
    seed = 8'h70;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cnt = '0;
    checks++;
    if ({data_w, wr_en, busy, done, sent_cnt} !== 27'd0) begin
      errors++;
      $display("FAIL reset_mid: got d=%h w=%b b=%b dn=%b c=%0d want all 0",
               data_w, wr_en, busy, done, sent_cnt);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done || wr_en) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid idle: got activity=%b want 0", seen);
    end
  endtask

`ifdef SEND_PRBS_EN
  task automatic test_prbs();
    logic [7:0] exp_seq [5];
    exp_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    burst_len = 8'd5;
    seed = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wr_en !== 1'b1 || data_w !== exp_seq[i]) begin
        errors++;
        $display("FAIL prbs beat%0d: got %b %h want 1 %h",
                 i, wr_en, data_w, exp_seq[i]);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_burst();
    test_backpressure();
    test_zero_len();
    test_busy_start();
    test_abort();
    test_reset_mid_burst();
`ifdef SEND_PRBS_EN
    test_prbs();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
